// File: rtl/gol_board_reader.sv
// Game of Life board reader: fetches one row per request and streams its cells in raster order
// over valid/ready, counting live cells per frame. Optional macro GOL_READER_SKIP_EMPTY_EN drops all-zero rows.
module gol_board_reader #(
    parameter int ROWS = 16,
    parameter int COLS = 16
) (
    input  logic                           ClkPort,
    input  logic                           reset_n,
    input  logic                           start,
    output logic                           rd_en,
    output logic [$clog2(ROWS)-1:0]        rd_row,
    input  logic [COLS-1:0]                rd_data,
    input  logic                           rd_valid,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_cell,
    output logic [$clog2(COLS)-1:0]        out_x,
    output logic [$clog2(ROWS)-1:0]        out_y,
    output logic                           out_last,
    output logic                           busy,
    output logic                           frame_done,
    output logic [$clog2(ROWS*COLS+1)-1:0] live_cnt
);

    localparam int YW = $clog2(ROWS);
    localparam int XW = $clog2(COLS);
    localparam int CW = $clog2(ROWS*COLS+1);
    localparam logic [XW-1:0] X_LAST = XW'(COLS-1);
    localparam bit ONE_COL = (COLS == 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SHIFT, S_DONE} state_t;

    state_t          state_q;
    logic [YW-1:0]   y_q;
    logic [COLS-1:0] rowbuf_q;
    logic [CW-1:0]   cnt_q;
    logic            rd_en_q;
    logic [YW-1:0]   rd_row_q;
    logic            out_valid_q;
    logic            out_cell_q;
    logic [XW-1:0]   out_x_q;
    logic [YW-1:0]   out_y_q;
    logic            out_last_q;
    logic            busy_q;
    logic            frame_done_q;
    logic [CW-1:0]   live_cnt_q;
`ifdef GOL_READER_SKIP_EMPTY_EN
    localparam logic [XW-1:0] X_PEN = XW'(COLS-2);
    // The last beat of a row is held back until a later non-empty row (or the end of the
    // board) is found, so out_last can mark the final beat actually emitted.
    logic            pend_q;
    logic            pend_out_q;
`endif

    logic            xfer;
    logic            last_row;
    logic [CW-1:0]   cnt_d;
    logic [YW-1:0]   y_next;
    logic [XW-1:0]   x_next;

    always_comb begin
        xfer     = out_valid_q & out_ready;
        last_row = (y_q == YW'(ROWS-1));
        cnt_d    = cnt_q + {{(CW-1){1'b0}}, xfer & out_cell_q};
        y_next   = y_q + YW'(1);
        x_next   = out_x_q + XW'(1);
    end

    always_ff @(posedge ClkPort or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            y_q          <= '0;
            rowbuf_q     <= '0;
            cnt_q        <= '0;
            rd_en_q      <= 1'b0;
            rd_row_q     <= '0;
            out_valid_q  <= 1'b0;
            out_cell_q   <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            live_cnt_q   <= '0;
`ifdef GOL_READER_SKIP_EMPTY_EN
            pend_q       <= 1'b0;
            pend_out_q   <= 1'b0;
`endif
        end else begin
            rd_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            cnt_q        <= cnt_d;
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (start) begin
                        state_q  <= S_REQ;
                        rd_en_q  <= 1'b1;
                        rd_row_q <= '0;
                        y_q      <= '0;
                        out_x_q  <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
`ifdef GOL_READER_SKIP_EMPTY_EN
                        pend_q   <= 1'b0;
`endif
                    end
                end
                S_REQ: state_q <= S_WAIT;
                S_WAIT: begin
                    if (rd_valid) begin
`ifdef GOL_READER_SKIP_EMPTY_EN
                        if (rd_data == '0) begin
                            if (!last_row) begin
                                state_q  <= S_REQ;
                                rd_en_q  <= 1'b1;
                                rd_row_q <= y_next;
                                y_q      <= y_next;
                            end else if (pend_q) begin
                                state_q     <= S_SHIFT;
                                pend_q      <= 1'b0;
                                pend_out_q  <= 1'b1;
                                out_valid_q <= 1'b1;
                                out_cell_q  <= rowbuf_q[COLS-1];
                                out_x_q     <= X_LAST;
                                out_last_q  <= 1'b1;
                            end else begin
                                state_q      <= S_DONE;
                                busy_q       <= 1'b0;
                                frame_done_q <= 1'b1;
                                live_cnt_q   <= cnt_d;
                            end
                        end else begin
                            rowbuf_q    <= rd_data;
                            state_q     <= S_SHIFT;
                            out_valid_q <= 1'b1;
                            if (pend_q) begin
                                pend_q     <= 1'b0;
                                pend_out_q <= 1'b1;
                                out_cell_q <= rowbuf_q[COLS-1];
                                out_x_q    <= X_LAST;
                                out_last_q <= 1'b0;
                            end else begin
                                out_cell_q <= rd_data[0];
                                out_x_q    <= '0;
                                out_y_q    <= y_q;
                                out_last_q <= last_row && ONE_COL;
                            end
                        end
`else
                        rowbuf_q    <= rd_data;
                        state_q     <= S_SHIFT;
                        out_valid_q <= 1'b1;
                        out_cell_q  <= rd_data[0];
                        out_x_q     <= '0;
                        out_y_q     <= y_q;
                        out_last_q  <= last_row && ONE_COL;
`endif
                    end
                end
                S_SHIFT: begin
                    if (xfer) begin
                        if (out_last_q) begin
                            state_q      <= S_DONE;
                            out_valid_q  <= 1'b0;
                            out_last_q   <= 1'b0;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                            live_cnt_q   <= cnt_d;
`ifdef GOL_READER_SKIP_EMPTY_EN
                        end else if (pend_out_q) begin
                            pend_out_q <= 1'b0;
                            out_cell_q <= rowbuf_q[0];
                            out_x_q    <= '0;
                            out_y_q    <= y_q;
                            out_last_q <= last_row && ONE_COL;
                        end else if (out_x_q == X_PEN && !last_row) begin
                            pend_q      <= 1'b1;
                            state_q     <= S_REQ;
                            rd_en_q     <= 1'b1;
                            rd_row_q    <= y_next;
                            y_q         <= y_next;
                            out_valid_q <= 1'b0;
`endif
                        end else if (out_x_q == X_LAST) begin
                            state_q     <= S_REQ;
                            rd_en_q     <= 1'b1;
                            rd_row_q    <= y_next;
                            y_q         <= y_next;
                            out_valid_q <= 1'b0;
                        end else begin
                            out_cell_q <= rowbuf_q[x_next];
                            out_x_q    <= x_next;
                            out_last_q <= last_row && (x_next == X_LAST);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_row     = rd_row_q;
    assign out_valid  = out_valid_q;
    assign out_cell   = out_cell_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign live_cnt   = live_cnt_q;

endmodule
